// File: rtl/msrv32_pkg.sv
// Shared encodings and constants for the msrv32 program-counter sequencer.
// Redirect-source codes are ordered so a numeric compare gives redirect priority.
package msrv32_pkg;

  typedef enum logic [1:0] {
    RESET_S = 2'd0,
    BOOT_S  = 2'd1,
    RUN_S   = 2'd2,
    HOLD_S  = 2'd3
  } pc_state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_BR   = 2'd1,
    SRC_MRET = 2'd2,
    SRC_TRAP = 2'd3
  } redir_src_e;

  localparam logic [31:0] WORD_INC = 32'd4;

  // A 32-bit instruction address must have both low bits clear.
  function automatic logic word_misaligned(input logic [31:0] addr);
    return addr[1];
  endfunction

endpackage

// File: rtl/msrv32_pc_mux.sv
// Next-PC priority select (trap > mret > branch > sequential) with the
// alignment check applied only to branch targets.
module msrv32_pc_mux
  import msrv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc_plus_4,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            trap_taken,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            mret,
  input  logic [XLEN-1:0] epc,
  output logic [XLEN-1:0] next_pc,
  output logic [1:0]      sel_src,
  output logic            misaligned
);

  // Priority select of the next PC and its source code.
  always_comb begin
    next_pc    = pc_plus_4;
    sel_src    = SRC_NONE;
    misaligned = 1'b0;
    if (trap_taken) begin
      next_pc = trap_vector;
      sel_src = SRC_TRAP;
    end else if (mret) begin
      next_pc = epc;
      sel_src = SRC_MRET;
    end else if (branch_taken) begin
      next_pc    = branch_target & 32'hFFFF_FFFE;
      sel_src    = SRC_BR;
      misaligned = word_misaligned(branch_target & 32'hFFFF_FFFE);
    end else begin
      next_pc = pc_plus_4;
    end
  end

endmodule

// File: rtl/msrv32_pc_ctrl.sv
// msrv32 program-counter sequencer: PC register, fetch handshake FSM and the
// pending-redirect latch that holds branch/trap/mret requests across stalls.
module msrv32_pc_ctrl
  import msrv32_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic            ms_riscv32_mp_clk_in,
  input  logic            ms_riscv32_mp_rst_in,
  input  logic            branch_taken_in,
  input  logic [XLEN-1:0] branch_target_in,
  input  logic            trap_taken_in,
  input  logic [XLEN-1:0] trap_vector_in,
  input  logic            mret_in,
  input  logic [XLEN-1:0] epc_in,
  input  logic            stall_in,
  input  logic            instr_ack_in,
  output logic            instr_req_out,
  output logic [XLEN-1:0] i_addr_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus_4_out,
  output logic [XLEN-1:0] pc_mux_out,
  output logic            misaligned_instr_out,
  output logic            fetch_valid_out
);

  pc_state_e       state_r;
  logic [XLEN-1:0] pc_r;
  logic            req_r;
  logic            misaligned_r;
  logic            fetch_valid_r;
  logic            pending_vld_r;
  logic [XLEN-1:0] pending_tgt_r;
  logic [1:0]      pending_src_r;

  logic [XLEN-1:0] pc_plus_4_s;
  logic [XLEN-1:0] next_pc_s;
  logic [1:0]      sel_src_s;
  logic            misaligned_s;
  logic            redirect_s;
  logic            take_new_s;

  assign pc_plus_4_s = pc_r + WORD_INC;
  assign redirect_s  = (sel_src_s != SRC_NONE);
  // Misaligned branches are never latched; equal priority replaces the older request.
  assign take_new_s  = redirect_s & ~misaligned_s &
                       (~pending_vld_r | (sel_src_s >= pending_src_r));

  msrv32_pc_mux #(.XLEN(XLEN)) u_pc_mux (
    .pc_plus_4     (pc_plus_4_s),
    .branch_taken  (branch_taken_in),
    .branch_target (branch_target_in),
    .trap_taken    (trap_taken_in),
    .trap_vector   (trap_vector_in),
    .mret          (mret_in),
    .epc           (epc_in),
    .next_pc       (next_pc_s),
    .sel_src       (sel_src_s),
    .misaligned    (misaligned_s)
  );

  // Sequencer FSM, PC register, registered handshake outputs and pending latch.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state_r       <= RESET_S;
      pc_r          <= BOOT_ADDR;
      req_r         <= 1'b0;
      misaligned_r  <= 1'b0;
      fetch_valid_r <= 1'b0;
      pending_vld_r <= 1'b0;
      pending_tgt_r <= 32'h0000_0000;
      pending_src_r <= SRC_NONE;
    end else begin
      case (state_r)
        RESET_S: begin
          state_r       <= BOOT_S;
          req_r         <= 1'b1;
          misaligned_r  <= 1'b0;
          fetch_valid_r <= 1'b0;
        end
        BOOT_S: begin
          misaligned_r  <= 1'b0;
          fetch_valid_r <= instr_ack_in;
          if (instr_ack_in) begin
            state_r <= RUN_S;
            pc_r    <= BOOT_ADDR + WORD_INC;
          end else begin
            state_r <= BOOT_S;
          end
        end
        RUN_S: begin
          misaligned_r  <= 1'b0;
          fetch_valid_r <= 1'b0;
          if (stall_in) begin
            state_r <= HOLD_S;
            req_r   <= 1'b0;
            if (take_new_s) begin
              pending_vld_r <= 1'b1;
              pending_tgt_r <= next_pc_s;
              pending_src_r <= sel_src_s;
            end
          end else if (redirect_s) begin
            if (misaligned_s) begin
              misaligned_r <= 1'b1;
            end else begin
              pc_r <= next_pc_s;
            end
          end else if (instr_ack_in) begin
            pc_r          <= next_pc_s;
            fetch_valid_r <= 1'b1;
          end else begin
            pc_r <= pc_r;
          end
        end
        HOLD_S: begin
          misaligned_r  <= 1'b0;
          fetch_valid_r <= 1'b0;
          if (stall_in) begin
            if (take_new_s) begin
              pending_vld_r <= 1'b1;
              pending_tgt_r <= next_pc_s;
              pending_src_r <= sel_src_s;
            end
          end else begin
            state_r       <= RUN_S;
            req_r         <= 1'b1;
            pending_vld_r <= 1'b0;
            pending_src_r <= SRC_NONE;
            if (take_new_s) begin
              pc_r <= next_pc_s;
            end else if (pending_vld_r) begin
              pc_r <= pending_tgt_r;
            end else begin
              pc_r <= pc_r;
            end
          end
        end
        default: begin
          state_r       <= RESET_S;
          pc_r          <= BOOT_ADDR;
          req_r         <= 1'b0;
          misaligned_r  <= 1'b0;
          fetch_valid_r <= 1'b0;
          pending_vld_r <= 1'b0;
        end
      endcase
    end
  end

  assign instr_req_out        = req_r;
  assign pc_out               = pc_r;
  assign i_addr_out           = pc_r;
  assign pc_plus_4_out        = pc_plus_4_s;
  assign pc_mux_out           = next_pc_s;
  assign misaligned_instr_out = misaligned_r;
  assign fetch_valid_out      = fetch_valid_r;

endmodule

// File: tb/tb_msrv32_pc_ctrl.sv
// Self-checking bench for msrv32_pc_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_msrv32_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        br, tr, mr, stall, ack;
  logic [31:0] bt, tv, ep;
  logic        req, mis, fv;
  logic [31:0] i_addr, pc, pc4, pcmux;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  localparam int P_RST = 0, P_BOOT = 1, P_RUN = 2, P_HOLD = 3;
  int          m_phase;
  logic [31:0] m_pc;
  logic        m_req, m_fv, m_mis;
  int          m_pend_src;
  logic [31:0] m_pend_tgt;

  always #5 clk = ~clk;

  msrv32_pc_ctrl dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst_n),
    .branch_taken_in      (br),
    .branch_target_in     (bt),
    .trap_taken_in        (tr),
    .trap_vector_in       (tv),
    .mret_in              (mr),
    .epc_in               (ep),
    .stall_in             (stall),
    .instr_ack_in         (ack),
    .instr_req_out        (req),
    .i_addr_out           (i_addr),
    .pc_out               (pc),
    .pc_plus_4_out        (pc4),
    .pc_mux_out           (pcmux),
    .misaligned_instr_out (mis),
    .fetch_valid_out      (fv)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase    = P_RST;
    m_pc       = 32'h0000_0000;
    m_req      = 1'b0;
    m_fv       = 1'b0;
    m_mis      = 1'b0;
    m_pend_src = 0;
    m_pend_tgt = 32'h0000_0000;
  endtask

  function automatic int req_src();
    if (tr) return 3;
    if (mr) return 2;
    if (br) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] req_tgt();
    if (tr) return tv;
    if (mr) return ep;
    if (br) return bt & 32'hFFFF_FFFE;
    return m_pc + 32'd4;
  endfunction

  // One clock edge of the reference behaviour, from the current inputs.
  task automatic model_step();
    int          src;
    logic [31:0] tgt;
    bit          bad;
    src = req_src();
    tgt = req_tgt();
    bad = (src == 1) && tgt[1];
    m_mis = 1'b0;
    case (m_phase)
      P_RST: begin
        m_phase = P_BOOT; m_req = 1'b1; m_fv = 1'b0;
      end
      P_BOOT: begin
        m_fv = ack;
        if (ack) begin m_pc = 32'd4; m_phase = P_RUN; end
      end
      P_RUN: begin
        m_fv = 1'b0;
        if (stall) begin
          m_phase = P_HOLD; m_req = 1'b0;
          if (src != 0 && !bad) begin m_pend_src = src; m_pend_tgt = tgt; end
        end else if (src != 0) begin
          if (bad) m_mis = 1'b1; else m_pc = tgt;
        end else if (ack) begin
          m_pc = m_pc + 32'd4; m_fv = 1'b1;
        end
      end
      default: begin
        m_fv = 1'b0;
        if (src != 0 && src >= m_pend_src) begin m_pend_src = src; m_pend_tgt = tgt; end
        if (!stall) begin
          m_phase = P_RUN; m_req = 1'b1;
          if (m_pend_src != 0) m_pc = m_pend_tgt;
          m_pend_src = 0;
        end
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #2;
  endtask

  // Compare every output against the model once per cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc_out", pc, m_pc);
      check("i_addr_out", i_addr, m_pc);
      check("pc_plus_4_out", pc4, m_pc + 32'd4);
      check("pc_mux_out", pcmux, req_tgt());
      check("instr_req_out", {31'd0, req}, {31'd0, m_req});
      check("fetch_valid_out", {31'd0, fv}, {31'd0, m_fv});
      check("misaligned_instr_out", {31'd0, mis}, {31'd0, m_mis});
    end
  end

  initial begin
    br = 1'b0; tr = 1'b0; mr = 1'b0; stall = 1'b0; ack = 1'b1;
    bt = 32'h0; tv = 32'h0; ep = 32'h0;
    model_reset();
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    #1;
    check("rst_req", {31'd0, req}, 32'd0);
    check("rst_pc", pc, 32'h0);
    repeat (2) tick();
    @(negedge clk) rst_n = 1'b1;

    tick();
    check("boot_req", {31'd0, req}, 32'd1);
    check("boot_addr", i_addr, 32'h0);
    tick(); check("seq_pc4", pc, 32'd4); check("seq_fv", {31'd0, fv}, 32'd1);
    tick(); check("seq_pc8", pc, 32'd8);
    tick(); check("seq_pc12", pc, 32'd12);

    br = 1'b1; bt = 32'h8; tick(); check("br_back8", pc, 32'h8);
    bt = 32'h101; tick(); check("br_bit0", pc, 32'h100);
    bt = 32'h8; tick();
    bt = 32'h102; tick();
    check("mis_hold", pc, 32'h8);
    check("mis_pulse", {31'd0, mis}, 32'd1);

    tr = 1'b1; tv = 32'h200; mr = 1'b1; ep = 32'h300; bt = 32'h400; tick();
    check("prio_trap", pc, 32'h200);
    check("mis_gone", {31'd0, mis}, 32'd0);
    tr = 1'b0; tick(); check("prio_mret", pc, 32'h300);
    mr = 1'b0;

    bt = 32'h10; tick(); check("pre_stall", pc, 32'h10);
    stall = 1'b1; bt = 32'h40; tick();
    check("stall1_pc", pc, 32'h10); check("stall1_req", {31'd0, req}, 32'd0);
    br = 1'b0; tr = 1'b1; tv = 32'h80; tick();
    check("stall2_pc", pc, 32'h10);
    tr = 1'b0; tick(); check("stall3_pc", pc, 32'h10);
    stall = 1'b0; tick();
    check("stall_redir", pc, 32'h80); check("stall_req", {31'd0, req}, 32'd1);

    br = 1'b1; bt = 32'hFFFF_FFFC; tick(); br = 1'b0;
    check("wrap_p4", pc4, 32'h0);
    ack = 1'b0; tick(); tick();
    check("wait_pc", pc, 32'hFFFF_FFFC);
    check("wait_req", {31'd0, req}, 32'd1);
    check("wait_fv", {31'd0, fv}, 32'd0);
    ack = 1'b1; tick(); check("wrap_pc", pc, 32'h0);

    stall = 1'b1; br = 1'b1; bt = 32'h500; tick();
    br = 1'b0;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_pc", pc, 32'h0);
    check("arst_req", {31'd0, req}, 32'd0);
    check("arst_fv", {31'd0, fv}, 32'd0);
    stall = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick(); check("arst_boot", i_addr, 32'h0);
    tick(); check("arst_nopend", pc, 32'h4);

    for (int i = 0; i < 3000; i++) begin
      ack   = ($urandom % 4) != 0;
      stall = ($urandom % 5) == 0;
      tr    = ($urandom % 12) == 0;
      mr    = ($urandom % 10) == 0;
      br    = ($urandom % 5) == 0;
      tv    = $urandom;
      ep    = $urandom;
      bt    = $urandom;
      if (!(m_phase == P_RUN && !stall)) bt[1] = 1'b0;
      if (($urandom % 500) == 0) begin
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
